// File: rtl/shadow_chain_source_pkg.sv
// rtl/shadow_chain_source_pkg.sv - shared state codes and chain status polarity
// Purpose: FSM state encoding and cin_status polarity constants shared with
//          chain_controller.
// Ports:   none (package)
package shadow_chain_source_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } chain_state_e;

  // Polarity of the status lane: high means the producer has nothing to offer.
  localparam logic CHAIN_EMPTY = 1'b1;
  localparam logic CHAIN_VALID = 1'b0;

endpackage

// File: rtl/shadow_fifo.sv
// rtl/shadow_fifo.sv - small synchronous snapshot FIFO
// Purpose: DATA_W x DEPTH buffer for snapshots waiting behind the shift register.
// Ports:   clk, rst (async, active-high)
//          push_i, din_i   - write a word
//          pop_i           - drop the head word
//          head_o          - current head word (valid when !empty_o)
//          full_o, empty_o - occupancy flags
module shadow_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  parameter int PTR_W  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic              do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/shadow_chain_source.sv
// rtl/shadow_chain_source.sv - shadow-capture chain producer lane
// Purpose: latch parallel snapshots, buffer them and shift them out LSB first,
//          one bit per chain_en edge, to one chain_controller input lane.
// Ports:   clk, rst (async, active-high)
//          capture, capture_data, capture_ready - snapshot request side
//          chain_en, chain_out, chain_status    - serial lane to the controller
//          overflow                             - sticky snapshot-dropped flag
module shadow_chain_source
  import shadow_chain_source_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 3,
  parameter int PTR_W  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic [DATA_W-1:0] capture_data,
  output logic              capture_ready,
  input  logic              chain_en,
  output logic              chain_out,
  output logic              chain_status,
  output logic              overflow
);

  chain_state_e      state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              status_q, status_d;
  logic              ovf_q, ovf_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              last_bit;

  assign last_bit = (state_q == ST_SHIFT) & chain_en & (cnt_q == CNT_W'(DATA_W - 1));
  assign fifo_pop = last_bit & ~fifo_empty;

  assign capture_ready = ~fifo_full | fifo_pop;

  // When the final bit leaves an otherwise empty pipeline the new snapshot goes
  // straight into the shifter instead of through the FIFO.
  assign fifo_push = (state_q == ST_SHIFT) & capture & capture_ready
                   & ~(last_bit & fifo_empty);

  shadow_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .din_i   (capture_data),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    ovf_d    = ovf_q | (capture & ~capture_ready);

    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          shift_d  = capture_data;
          cnt_d    = '0;
          state_d  = ST_SHIFT;
          status_d = CHAIN_VALID;
        end
      end
      ST_SHIFT: begin
        if (chain_en) begin
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_d = '0;
            if (!fifo_empty) begin
              shift_d = fifo_head;
            end else if (capture) begin
              shift_d = capture_data;
            end else begin
              shift_d  = '0;
              state_d  = ST_IDLE;
              status_d = CHAIN_EMPTY;
            end
          end else begin
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        status_d = CHAIN_EMPTY;
        shift_d  = '0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      status_q <= CHAIN_EMPTY;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      ovf_q    <= ovf_d;
    end
  end

  // Shifter bit 0 is the current serial bit; the shifter is cleared on return to IDLE.
  assign chain_out    = shift_q[0];
  assign chain_status = status_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_shadow_chain_source.sv
// tb/tb_shadow_chain_source.sv - directed self-checking bench for shadow_chain_source
module tb_shadow_chain_source;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       capture = 1'b0;
  logic [7:0] capture_data = 8'h00;
  logic       chain_en = 1'b0;
  logic       capture_ready;
  logic       chain_out;
  logic       chain_status;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  shadow_chain_source #(
    .DATA_W (8),
    .DEPTH  (2),
    .CNT_W  (3),
    .PTR_W  (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .capture       (capture),
    .capture_data  (capture_data),
    .capture_ready (capture_ready),
    .chain_en      (chain_en),
    .chain_out     (chain_out),
    .chain_status  (chain_status),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expect nbits of word on chain_out, LSB first, consuming one bit per cycle.
  task automatic drain_bits(input string tag, input logic [31:0] word, input int nbits);
    chain_en = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      check_val({tag, "_bit"}, {31'd0, chain_out}, {31'd0, word[i]});
      check_val({tag, "_st"}, {31'd0, chain_status}, 32'd0);
      step();
    end
  endtask

  initial begin
    logic [7:0]  w8;
    logic [15:0] w16;
    int          k;
    int          cyc;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_status", {31'd0, chain_status}, 32'd1);
    check_val("rst_out",    {31'd0, chain_out},    32'd0);
    check_val("rst_ready",  {31'd0, capture_ready}, 32'd1);
    check_val("rst_ovf",    {31'd0, overflow},     32'd0);
    rst = 1'b0;
    step();

    // 8'hA5 with chain_en held high
    chain_en = 1'b1;
    capture = 1'b1; capture_data = 8'hA5;
    step();
    capture = 1'b0;
    drain_bits("a5", 32'h000000A5, 8);
    check_val("a5_end_st",  {31'd0, chain_status}, 32'd1);
    check_val("a5_end_out", {31'd0, chain_out},    32'd0);

    // 8'h3C with stalls: chain_en 1,0,0,1,0,0,...
    chain_en = 1'b0;
    capture = 1'b1; capture_data = 8'h3C;
    step();
    capture = 1'b0;
    w8 = 8'h3C;
    k = 0;
    cyc = 0;
    while (k < 8 && cyc < 64) begin
      chain_en = (cyc % 3 == 0);
      check_val("stall_bit", {31'd0, chain_out},    {31'd0, w8[k]});
      check_val("stall_st",  {31'd0, chain_status}, 32'd0);
      step();
      if (chain_en) k++;
      cyc++;
    end
    check_val("stall_done", k, 8);
    chain_en = 1'b0;
    check_val("stall_end_st", {31'd0, chain_status}, 32'd1);

    // 8'h0F then 8'hF0 on consecutive cycles: 16 contiguous bits
    chain_en = 1'b1;
    capture = 1'b1; capture_data = 8'h0F;
    step();
    w16 = 16'hF00F;
    check_val("b2b_bit", {31'd0, chain_out},    {31'd0, w16[0]});
    check_val("b2b_st",  {31'd0, chain_status}, 32'd0);
    capture_data = 8'hF0;
    step();
    capture = 1'b0;
    drain_bits("b2b", {17'd0, w16[15:1]}, 15);
    check_val("b2b_end_st", {31'd0, chain_status}, 32'd1);

    // Fill with chain_en low, then drop a fourth snapshot
    chain_en = 1'b0;
    capture = 1'b1; capture_data = 8'h01;
    step();
    capture_data = 8'h02;
    step();
    capture_data = 8'h03;
    step();
    capture_data = 8'h04;
    check_val("full_ready", {31'd0, capture_ready}, 32'd0);
    check_val("full_ovf0",  {31'd0, overflow},      32'd0);
    step();
    capture = 1'b0;
    check_val("drop_ovf", {31'd0, overflow}, 32'd1);
    drain_bits("drain", 32'h00030201, 24);
    check_val("drain_end_st",  {31'd0, chain_status}, 32'd1);
    check_val("drain_ovf_hold", {31'd0, overflow},    32'd1);

    // Asynchronous reset in the middle of a word
    chain_en = 1'b1;
    capture = 1'b1; capture_data = 8'h55;
    step();
    capture = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_status", {31'd0, chain_status}, 32'd1);
    check_val("mid_rst_out",    {31'd0, chain_out},    32'd0);
    check_val("mid_rst_ready",  {31'd0, capture_ready}, 32'd1);
    check_val("mid_rst_ovf",    {31'd0, overflow},     32'd0);
    step();
    rst = 1'b0;
    chain_en = 1'b0;
    step();
    check_val("post_rst_status", {31'd0, chain_status}, 32'd1);

    // FIFO full, capture on the edge the last shifter bit is consumed
    chain_en = 1'b0;
    capture = 1'b1; capture_data = 8'h11;
    step();
    capture_data = 8'h22;
    step();
    capture_data = 8'h33;
    step();
    capture = 1'b0;
    check_val("edge_full_ready", {31'd0, capture_ready}, 32'd0);
    chain_en = 1'b1;
    w8 = 8'h11;
    for (int i = 0; i < 7; i++) begin
      check_val("edge_bit", {31'd0, chain_out}, {31'd0, w8[i]});
      step();
    end
    check_val("edge_last_bit", {31'd0, chain_out}, {31'd0, w8[7]});
    capture = 1'b1; capture_data = 8'hAA;
    check_val("edge_ready", {31'd0, capture_ready}, 32'd1);
    step();
    capture = 1'b0;
    check_val("edge_ovf", {31'd0, overflow}, 32'd0);
    drain_bits("edge", 32'h00AA3322, 24);
    check_val("edge_end_st",  {31'd0, chain_status}, 32'd1);
    check_val("edge_end_ovf", {31'd0, overflow},     32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
